bldc_pwm_bank: RTL and testbench
================================

Name: bldc_pwm_bank

Overview:
- Multi-phase PWM generator for the BLDC power stage. Replaces the per-phase driver with one shared period counter and NUM_PHASES compare channels.
- Adds the following over the per-phase driver:
  - period-boundary (glitch-free) duty and high-Z update
  - a guaranteed non-overlap invariant
  - a latched fault shutdown
  - a period_start strobe for ADC current-sample alignment
- Sits between the motor commutation/control logic and the gate-driver pins.

Parameters:
- NUM_PHASES, 3, number of half-bridges driven
- DUTY_WIDTH, 9, bits per duty word; DUTY_MAX = 2^DUTY_WIDTH-1
- DUTY_STEP, 2, counter ticks per duty LSB; compare value T = duty*DUTY_STEP
- COUNTER_WIDTH, 10, counter width; must hold PERIOD-1
- PERIOD, 1022, counts per PWM period (= DUTY_MAX*DUTY_STEP)
- DEAD_TIME, 8, dead-band in clock ticks, applied at every high/low transition

Ports:
- clock, input, 1, system clock
- reset, input, 1, synchronous, active-high
- duty_cycle, input, NUM_PHASES*DUTY_WIDTH, packed duty words; phase 0 in the LSBs
- high_z, input, NUM_PHASES, per-phase float request
- enable, input, 1, global output enable
- fault, input, 1, overcurrent/driver fault, level
- fault_clear, input, 1, fault latch release, level
- pwm_high, output, NUM_PHASES, high-side FET gates
- pwm_low, output, NUM_PHASES, low-side FET gates
- period_start, output, 1, one-cycle strobe at counter == 0
- faulted, output, 1, fault latch state

Behaviour:

Reset:
- counter=0; all pwm_high/pwm_low=0; period_start=0; faulted=0.
- Shadow duty=0; shadow high_z=all 1; armed=0.
- Reset mid-period: outputs are 0 in the cycle after reset is sampled.

Counter:
- Edge-aligned: counts 0..PERIOD-1, then wraps to 0.
- Runs regardless of enable/fault.

Shadow registers:
- In the cycle counter==PERIOD-1, duty_cycle, high_z and enable are captured. armed <= enable.
- They take effect from count 0.
- Input changes at any other time have no effect on the current period.

Output latency:
- Outputs are registered. Outputs in cycle k+1 are a function of counter and shadow values in cycle k.
- period_start is registered the same way: high the cycle after counter==0.

Per-phase compare, T = duty*DUTY_STEP, counter value c:
- duty==0: high=0, low=1 for the whole period (no dead-band).
- duty==DUTY_MAX: high=1, low=0 for the whole period.
- Otherwise:
  - high = (c >= DEAD_TIME && c < T)
  - low = (c >= T+DEAD_TIME && c < PERIOD)
- T <= DEAD_TIME: high never asserts (minimum-pulse suppression); low still follows its rule.
- Width rule: T+DEAD_TIME is computed COUNTER_WIDTH+1 wide so it cannot wrap.

Gating, applied to the registered outputs:
- Shadow high_z[i]=1 forces pwm_high[i]=pwm_low[i]=0.
- armed=0 forces all outputs 0.
- Deasserting enable forces all outputs 0 the next cycle, bypassing the shadow.
- Re-asserting enable takes effect at the next period boundary.

Fault FSM, states RUN and FAULT:
- RUN -> FAULT when fault=1. Outputs are all 0 from the next cycle (non-shadowed); faulted=1.
- FAULT -> RUN when fault_clear=1 && fault=0. faulted drops the next cycle.
- On leaving FAULT, outputs stay 0 until the next period_start. They resume only if enable was captured high.
- fault and fault_clear high together: stay in or enter FAULT (fault wins).

Invariant:
- pwm_high[i] & pwm_low[i] == 0 in every cycle, in every mode.
- Enforced by a final gate: low is masked whenever high is set.

Optional Feature:
PWM_CENTER_ALIGNED_EN
- Defined:
  - The counter is an up/down triangle: 0 -> PERIOD/2-1 -> 0.
  - Compare value is C = T>>1.
  - Rules: high = (c < C); low = (c >= C+DEAD_TIME). This gives DEAD_TIME gaps on both edges.
  - duty 0 and DUTY_MAX are handled as in edge-aligned mode.
  - Shadow capture and period_start occur at c==0 while counting down→up. The high pulse is centred on period_start.
  - Period length is unchanged (PERIOD clocks).
- Undefined: edge-aligned counter only; the triangle/direction logic is not synthesised.

Test Plan (defaults: DEAD_TIME=8, DUTY_STEP=2, PERIOD=1022):
1. Phase 0 duty=0, then 511 → full period low=1/high=0, then high=1/low=0. Never both high; no dead-band cycles.
2. duty=256, T=512 → per period:
   - high for counts 8..511 (504 cycles)
   - low for 520..1021 (502 cycles)
   - both low for 16 cycles
   - period_start every 1022 clocks
3. duty changed 100→300 at count 400 → current period keeps a high edge at 200. The next period falls at count 600.
4. duty=3 (T=6 ≤ 8) → pwm_high never asserts; pwm_low high for counts 14..1021.
5. Fault at count 300 → all outputs 0 next cycle, faulted=1. fault_clear while fault=1 is ignored. After fault=0 and a fault_clear pulse, faulted=0 and outputs resume at the next period_start.
6. Reset asserted at count 700 with high_z=0 and enable=1 → next cycle: counter=0, outputs 0. Outputs stay 0 until one full period passes and the shadow captures enable=1.

Source files
------------

// File: rtl/bldc_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : bldc_pwm_bank
// Purpose  : Multi-phase PWM generator for a BLDC power stage. One shared
//            period counter drives NUM_PHASES compare channels. Duty, high-Z
//            and enable are shadowed and take effect at period boundaries.
//            Each edge gets a dead band, and the high/low gates of a phase
//            are never active together. A latched fault shuts all outputs.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            duty_cycle        - packed duty words, phase 0 in the LSBs
//            high_z            - per-phase float request (shadowed)
//            enable            - global output enable
//            fault/fault_clear - fault level input / latch release
//            pwm_high/pwm_low  - high-side / low-side gate drives
//            period_start      - one-cycle strobe aligned with count 0
//            faulted           - fault latch state
// Options  : PWM_CENTER_ALIGNED_EN - up/down triangle counter with
//            symmetric compare (default build: edge-aligned counter)
// Revision : 1.0 - initial release
// ============================================================================
module bldc_pwm_bank #(
    parameter int NUM_PHASES    = 3,
    parameter int DUTY_WIDTH    = 9,
    parameter int DUTY_STEP     = 2,
    parameter int COUNTER_WIDTH = 10,
    parameter int PERIOD        = 1022,
    parameter int DEAD_TIME     = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PHASES*DUTY_WIDTH-1:0] duty_cycle,
    input  logic [NUM_PHASES-1:0]            high_z,
    input  logic                             enable,
    input  logic                             fault,
    input  logic                             fault_clear,
    output logic [NUM_PHASES-1:0]            pwm_high,
    output logic [NUM_PHASES-1:0]            pwm_low,
    output logic                             period_start,
    output logic                             faulted
);

    // Compare arithmetic is one bit wider than the counter so that
    // T + DEAD_TIME can never wrap.
    localparam int                    TW         = COUNTER_WIDTH + 1;
    localparam logic [TW-1:0]         c_dead     = TW'(DEAD_TIME);
    localparam logic [TW-1:0]         c_step     = TW'(DUTY_STEP);
    localparam logic [DUTY_WIDTH-1:0] c_duty_max = '1;

    // ------------------------------------------------------------------
    // Fault FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // fault has priority over fault_clear.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (fault) w_state_nxt = ST_FAULT;
            ST_FAULT: if (fault_clear && !fault) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    assign faulted = (r_state == ST_FAULT);

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     w_boundary;
    logic                     w_ps_src;

`ifdef PWM_CENTER_ALIGNED_EN
    // Triangle 0 -> PERIOD/2-1 -> 0. Each turning point is held for one
    // extra cycle while the direction flips, keeping the period at PERIOD.
    localparam logic [COUNTER_WIDTH-1:0] c_half_last = COUNTER_WIDTH'(PERIOD/2 - 1);
    logic r_dir_up;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else if (r_dir_up) begin
            if (r_cnt == c_half_last) r_dir_up <= 1'b0;
            else                      r_cnt    <= r_cnt + 1'b1;
        end else begin
            if (r_cnt == '0) r_dir_up <= 1'b1;
            else             r_cnt    <= r_cnt - 1'b1;
        end
    end

    // The down->up turnaround at zero is both the capture point and the
    // period strobe source, so the high pulse straddles period_start.
    assign w_boundary = (r_cnt == '0) && !r_dir_up;
    assign w_ps_src   = w_boundary;
`else
    localparam logic [COUNTER_WIDTH-1:0] c_last   = COUNTER_WIDTH'(PERIOD - 1);
    localparam logic [TW-1:0]            c_period = TW'(PERIOD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_boundary = (r_cnt == c_last);
    assign w_ps_src   = (r_cnt == '0);
`endif

    logic [TW-1:0] w_cnt_x;
    assign w_cnt_x = {1'b0, r_cnt};

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    logic [NUM_PHASES*DUTY_WIDTH-1:0] r_duty_sh;
    logic [NUM_PHASES-1:0]            r_hz_sh;
    logic                             r_armed;

    // armed drops immediately on fault or enable loss and can only be set
    // again at a boundary, so recovery always starts on a clean period.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_duty_sh <= '0;
            r_hz_sh   <= '1;
            r_armed   <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_duty_sh <= duty_cycle;
                r_hz_sh   <= high_z;
            end
            if ((r_state == ST_FAULT) || fault || !enable) begin
                r_armed <= 1'b0;
            end else if (w_boundary) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Live enable and fault bypass the shadow for a next-cycle shutdown.
    logic w_run_ok;
    assign w_run_ok = (r_state == ST_RUN) && !fault && enable && r_armed;

    // ------------------------------------------------------------------
    // Per-phase compare
    // ------------------------------------------------------------------
    logic [NUM_PHASES-1:0] w_high_nxt;
    logic [NUM_PHASES-1:0] w_low_nxt;

    generate
        for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
            logic [DUTY_WIDTH-1:0] w_duty;
            logic [TW-1:0]         w_t;
            logic                  w_hi_raw;
            logic                  w_lo_raw;
            logic                  w_hi;
            logic                  w_lo;
            logic                  w_gate;

            assign w_duty = r_duty_sh[i*DUTY_WIDTH +: DUTY_WIDTH];
            assign w_t    = TW'(w_duty) * c_step;

`ifdef PWM_CENTER_ALIGNED_EN
            logic [TW-1:0] w_c;
            assign w_c      = w_t >> 1;
            assign w_hi_raw = (w_cnt_x < w_c);
            assign w_lo_raw = (w_cnt_x >= w_c + c_dead);
`else
            // T <= DEAD_TIME leaves the high window empty: minimum-pulse
            // suppression falls out of the comparison itself.
            assign w_hi_raw = (w_cnt_x >= c_dead) && (w_cnt_x < w_t);
            assign w_lo_raw = (w_cnt_x >= w_t + c_dead) && (w_cnt_x < c_period);
`endif

            // Rail duties bypass the dead band entirely.
            assign w_hi = (w_duty == '0)         ? 1'b0 :
                          (w_duty == c_duty_max) ? 1'b1 : w_hi_raw;
            assign w_lo = (w_duty == '0)         ? 1'b1 :
                          (w_duty == c_duty_max) ? 1'b0 : w_lo_raw;

            assign w_gate        = w_run_ok && !r_hz_sh[i];
            assign w_high_nxt[i] = w_hi && w_gate;
            // Final shoot-through guard: low never coexists with high.
            assign w_low_nxt[i]  = w_lo && w_gate && !w_high_nxt[i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_high     <= '0;
            pwm_low      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_high     <= w_high_nxt;
            pwm_low      <= w_low_nxt;
            period_start <= w_ps_src;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bldc_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_bldc_pwm_bank
// Purpose  : Self-checking bench for bldc_pwm_bank (default, edge-aligned
//            build). Expected values are queued as stimulus is applied and
//            compared against measured output behaviour per period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bldc_pwm_bank;

    localparam int NP  = 3;
    localparam int DW  = 9;
    localparam int PER = 1022;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NP*DW-1:0]   duty_cycle;
    logic [NP-1:0]      high_z;
    logic               enable;
    logic               fault;
    logic               fault_clear;
    logic [NP-1:0]      pwm_high;
    logic [NP-1:0]      pwm_low;
    logic               period_start;
    logic               faulted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   act_q[$];

    // Per-period measurements (index j = counter value the outputs reflect)
    int m_hi  [NP];
    int m_lo  [NP];
    int m_gap [NP];
    int m_fh  [NP];
    int m_lh  [NP];
    int m_fl  [NP];
    int m_both;
    int m_any;
    int m_mid_ps;
    int m_end_ps;

    bldc_pwm_bank dut (
        .clock        (clock),
        .reset        (reset),
        .duty_cycle   (duty_cycle),
        .high_z       (high_z),
        .enable       (enable),
        .fault        (fault),
        .fault_clear  (fault_clear),
        .pwm_high     (pwm_high),
        .pwm_low      (pwm_low),
        .period_start (period_start),
        .faulted      (faulted)
    );

    always #5 clock = ~clock;

    function automatic logic [NP*DW-1:0] pack(input int d2, input int d1, input int d0);
        logic [DW-1:0] a2, a1, a0;
        a2 = DW'(d2);
        a1 = DW'(d1);
        a0 = DW'(d0);
        return {a2, a1, a0};
    endfunction

    task automatic push_exp(input string n, input int v);
        exp_t e;
        e.name = n;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Records one full period starting at a period_start sample; optionally
    // rewrites duty_cycle at sample chg_j.
    task automatic measure(input int chg_j, input logic [NP*DW-1:0] chg_val);
        for (int p = 0; p < NP; p++) begin
            m_hi[p] = 0; m_lo[p] = 0; m_gap[p] = 0;
            m_fh[p] = -1; m_lh[p] = -1; m_fl[p] = -1;
        end
        m_both = 0; m_any = 0; m_mid_ps = 0;
        for (int j = 0; j < PER; j++) begin
            if (j > 0 && period_start) m_mid_ps++;
            if ((pwm_high & pwm_low) != '0) m_both++;
            if ((pwm_high | pwm_low) != '0) m_any++;
            for (int p = 0; p < NP; p++) begin
                if (pwm_high[p]) begin
                    m_hi[p]++;
                    if (m_fh[p] < 0) m_fh[p] = j;
                    m_lh[p] = j;
                end
                if (pwm_low[p]) begin
                    m_lo[p]++;
                    if (m_fl[p] < 0) m_fl[p] = j;
                end
                if (!pwm_high[p] && !pwm_low[p]) m_gap[p]++;
            end
            if (j == chg_j) duty_cycle = chg_val;
            @(negedge clock);
        end
        m_end_ps = period_start;
    endtask

    task automatic test_reset();
        exp_t e; int a;
        push_exp("reset_high", 0);
        push_exp("reset_low", 0);
        push_exp("reset_period_start", 0);
        push_exp("reset_faulted", 0);
        reset = 1'b1; enable = 1'b1; high_z = '0; fault = 1'b0; fault_clear = 1'b0;
        duty_cycle = pack(128, 0, 256);
        repeat (3) @(negedge clock);
        act_q.push_back(int'(pwm_high));
        act_q.push_back(int'(pwm_low));
        act_q.push_back(int'(period_start));
        act_q.push_back(int'(faulted));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_duty_256();
        exp_t e; int a;
        push_exp("first_ps_after_reset", 1);
        push_exp("unarmed_period_active", 0);
        push_exp("unarmed_period_end_ps", 1);
        push_exp("d256_hi", 504);   push_exp("d256_first_hi", 8);
        push_exp("d256_last_hi", 511); push_exp("d256_lo", 502);
        push_exp("d256_first_lo", 520); push_exp("d256_gap", 16);
        push_exp("d0_p1_lo", 1022); push_exp("d128_p2_hi", 248);
        push_exp("d128_p2_lo", 758); push_exp("overlap", 0);
        push_exp("mid_period_ps", 0); push_exp("period_len_ps", 1);
        reset = 1'b0;
        @(negedge clock);
        act_q.push_back(int'(period_start));
        measure(-1, duty_cycle);
        act_q.push_back(m_any);
        act_q.push_back(m_end_ps);
        measure(-1, duty_cycle);
        act_q.push_back(m_hi[0]); act_q.push_back(m_fh[0]);
        act_q.push_back(m_lh[0]); act_q.push_back(m_lo[0]);
        act_q.push_back(m_fl[0]); act_q.push_back(m_gap[0]);
        act_q.push_back(m_lo[1]); act_q.push_back(m_hi[2]);
        act_q.push_back(m_lo[2]); act_q.push_back(m_both);
        act_q.push_back(m_mid_ps); act_q.push_back(m_end_ps);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_duty_extremes();
        exp_t e; int a;
        push_exp("midperiod_change_ignored_hi", 504);
        push_exp("duty0_hi", 0);   push_exp("duty0_lo", 1022);  push_exp("duty0_gap", 0);
        push_exp("dmax_p1_hi", 1022); push_exp("dmax_p1_lo", 0); push_exp("rails_overlap", 0);
        push_exp("dmax_hi", 1022); push_exp("dmax_lo", 0);      push_exp("dmax_gap", 0);
        measure(0, pack(128, 511, 0));
        act_q.push_back(m_hi[0]);
        measure(0, pack(128, 0, 511));
        act_q.push_back(m_hi[0]); act_q.push_back(m_lo[0]); act_q.push_back(m_gap[0]);
        act_q.push_back(m_hi[1]); act_q.push_back(m_lo[1]); act_q.push_back(m_both);
        measure(0, pack(128, 0, 100));
        act_q.push_back(m_hi[0]); act_q.push_back(m_lo[0]); act_q.push_back(m_gap[0]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_mid_update();
        exp_t e; int a;
        push_exp("d100_last_hi", 199); push_exp("d100_hi", 192);
        push_exp("d100_first_lo", 208); push_exp("d100_lo", 814);
        push_exp("d300_last_hi", 599); push_exp("d300_hi", 592);
        push_exp("d300_first_lo", 608); push_exp("d300_lo", 414);
        measure(399, pack(128, 0, 300));
        act_q.push_back(m_lh[0]); act_q.push_back(m_hi[0]);
        act_q.push_back(m_fl[0]); act_q.push_back(m_lo[0]);
        measure(0, pack(5, 4, 3));
        act_q.push_back(m_lh[0]); act_q.push_back(m_hi[0]);
        act_q.push_back(m_fl[0]); act_q.push_back(m_lo[0]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_min_pulse();
        exp_t e; int a;
        push_exp("t6_hi", 0);  push_exp("t6_first_lo", 14); push_exp("t6_lo", 1008);
        push_exp("t8_hi", 0);  push_exp("t8_first_lo", 16); push_exp("t8_lo", 1006);
        push_exp("t10_hi", 2); push_exp("t10_first_hi", 8); push_exp("t10_last_hi", 9);
        push_exp("t10_lo", 1004);
        measure(0, pack(128, 0, 256));
        act_q.push_back(m_hi[0]); act_q.push_back(m_fl[0]); act_q.push_back(m_lo[0]);
        act_q.push_back(m_hi[1]); act_q.push_back(m_fl[1]); act_q.push_back(m_lo[1]);
        act_q.push_back(m_hi[2]); act_q.push_back(m_fh[2]); act_q.push_back(m_lh[2]);
        act_q.push_back(m_lo[2]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_fault();
        exp_t e; int a; bit ok; int nz;
        push_exp("flt_pre_high0", 1);      push_exp("flt_pre_faulted", 0);
        push_exp("flt_high_off", 0);       push_exp("flt_low_off", 0);
        push_exp("flt_faulted", 1);        push_exp("flt_clear_ignored", 1);
        push_exp("flt_clear_ignored_out", 0); push_exp("flt_still_latched", 1);
        push_exp("flt_released", 0);       push_exp("flt_quiet_until_ps", 0);
        push_exp("flt_ps_found", 1);       push_exp("flt_resume_low1", 1);
        push_exp("flt_resume_hi0", 504);
        repeat (299) @(negedge clock);
        act_q.push_back(int'(pwm_high[0]));
        act_q.push_back(int'(faulted));
        fault = 1'b1;
        @(negedge clock);
        act_q.push_back(int'(pwm_high));
        act_q.push_back(int'(pwm_low));
        act_q.push_back(int'(faulted));
        fault_clear = 1'b1;
        repeat (4) @(negedge clock);
        act_q.push_back(int'(faulted));
        act_q.push_back(int'(pwm_high | pwm_low));
        fault = 1'b0; fault_clear = 1'b0;
        repeat (3) @(negedge clock);
        act_q.push_back(int'(faulted));
        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        act_q.push_back(int'(faulted));
        ok = 1'b0; nz = 0;
        for (int i = 0; i < 2*PER; i++) begin
            if (period_start) begin
                ok = 1'b1;
                break;
            end
            if ((pwm_high | pwm_low) != '0) nz++;
            @(negedge clock);
        end
        act_q.push_back(nz);
        act_q.push_back(int'(ok));
        act_q.push_back(int'(pwm_low[1]));
        measure(-1, duty_cycle);
        act_q.push_back(m_hi[0]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_enable_highz();
        exp_t e; int a; bit ok; int nz;
        push_exp("en_pre_high0", 1);  push_exp("en_drop_outputs", 0);
        push_exp("en_quiet_until_ps", 0); push_exp("en_ps_found", 1);
        push_exp("en_resume_hi0", 504); push_exp("hz_p1_lo", 0);
        push_exp("hz_p1_hi", 0);       push_exp("hz_p2_hi", 248);
        repeat (100) @(negedge clock);
        act_q.push_back(int'(pwm_high[0]));
        enable = 1'b0;
        @(negedge clock);
        act_q.push_back(int'(pwm_high | pwm_low));
        enable = 1'b1;
        high_z = 3'b010;
        ok = 1'b0; nz = 0;
        for (int i = 0; i < 2*PER; i++) begin
            if (period_start) begin
                ok = 1'b1;
                break;
            end
            if ((pwm_high | pwm_low) != '0) nz++;
            @(negedge clock);
        end
        act_q.push_back(nz);
        act_q.push_back(int'(ok));
        high_z = '0;
        measure(-1, duty_cycle);
        act_q.push_back(m_hi[0]); act_q.push_back(m_lo[1]);
        act_q.push_back(m_hi[1]); act_q.push_back(m_hi[2]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e; int a;
        push_exp("rm_pre_low1", 1);     push_exp("rm_outputs_off", 0);
        push_exp("rm_ps_off", 0);       push_exp("rm_first_ps", 1);
        push_exp("rm_unarmed_active", 0); push_exp("rm_end_ps", 1);
        push_exp("rm_resume_low1", 1);
        repeat (699) @(negedge clock);
        act_q.push_back(int'(pwm_low[1]));
        reset = 1'b1;
        @(negedge clock);
        act_q.push_back(int'(pwm_high | pwm_low));
        act_q.push_back(int'(period_start));
        reset = 1'b0;
        @(negedge clock);
        act_q.push_back(int'(period_start));
        measure(-1, duty_cycle);
        act_q.push_back(m_any);
        act_q.push_back(m_end_ps);
        act_q.push_back(int'(pwm_low[1]));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = -999;
            if (act_q.size() > 0) a = act_q.pop_front();
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.name, a, e.val);
            end
        end
        act_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        duty_cycle  = '0;
        high_z      = '0;
        enable      = 1'b0;
        fault       = 1'b0;
        fault_clear = 1'b0;
        test_reset();
        test_duty_256();
        test_duty_extremes();
        test_mid_update();
        test_min_pulse();
        test_fault();
        test_enable_highz();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
